// File: rtl/operand_entry.sv
// operand_entry: debounced push-button entry of two BCD operands from a
// 4-bit switch field. Produces their registered 5-bit sum with a valid flag
// for the downstream two-digit display, plus an error flag for out-of-range
// entries and the FSM state for LED indication.
module operand_entry #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic       CLOCK_50,
    input  logic       resetn,
    input  logic [3:0] sw,
    input  logic       key_n,
    output logic [4:0] sum,
    output logic       sum_valid,
    output logic [1:0] state,
    output logic       err
);

    // Counter only needs to reach DEBOUNCE_CYCLES-1.
    localparam int                CNT_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_ZERO = CNT_W'(0);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_GET_A = 2'b00,
        ST_GET_B = 2'b01,
        ST_SHOW  = 2'b10
    } state_t;

    // True when the switch field holds a single decimal digit.
    function automatic logic is_bcd(input logic [3:0] v);
        return (v <= 4'd9);
    endfunction

    logic             r_sync1;
    logic             r_sync2;
    logic             r_key_d;
    logic             r_key_d_dly;
    logic [CNT_W-1:0] r_cnt;
    logic             r_press;

    state_t           r_state;
    logic [3:0]       r_a;
    logic [4:0]       r_sum;
    logic             r_sum_valid;
    logic             r_err;

    state_t           w_state_nxt;
    logic [3:0]       w_a_nxt;
    logic [4:0]       w_sum_nxt;
    logic             w_sum_valid_nxt;
    logic             w_err_nxt;

    // Two-flop synchronizer bringing the asynchronous button into CLOCK_50.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= key_n;
            r_sync2 <= r_sync1;
        end
    end

    // Accept a new key level only after it has differed for the full window.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            r_key_d <= 1'b1;
            r_cnt   <= CNT_ZERO;
        end else if (r_sync2 == r_key_d) begin
            r_key_d <= r_key_d;
            r_cnt   <= CNT_ZERO;
        end else if (r_cnt == CNT_LAST) begin
            r_key_d <= r_sync2;
            r_cnt   <= CNT_ZERO;
        end else begin
            r_key_d <= r_key_d;
            r_cnt   <= r_cnt + CNT_ONE;
        end
    end

    // One-cycle press pulse registered the cycle after the debounced level falls.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            r_key_d_dly <= 1'b1;
            r_press     <= 1'b0;
        end else begin
            r_key_d_dly <= r_key_d;
            r_press     <= r_key_d_dly & ~r_key_d;
        end
    end

    // Entry FSM next-state and datapath; everything holds unless a press arrives.
    always_comb begin
        w_state_nxt     = r_state;
        w_a_nxt         = r_a;
        w_sum_nxt       = r_sum;
        w_sum_valid_nxt = r_sum_valid;
        w_err_nxt       = r_err;
        if (r_press) begin
            case (r_state)
                ST_GET_A: begin
                    if (is_bcd(sw)) begin
                        w_a_nxt     = sw;
                        w_err_nxt   = 1'b0;
                        w_state_nxt = ST_GET_B;
                    end else begin
                        w_err_nxt   = 1'b1;
                    end
                end
                ST_GET_B: begin
                    if (is_bcd(sw)) begin
                        w_sum_nxt       = {1'b0, r_a} + {1'b0, sw};
                        w_sum_valid_nxt = 1'b1;
                        w_err_nxt       = 1'b0;
                        w_state_nxt     = ST_SHOW;
                    end else begin
                        w_err_nxt       = 1'b1;
                    end
                end
                ST_SHOW: begin
                    w_sum_nxt       = 5'd0;
                    w_sum_valid_nxt = 1'b0;
                    w_err_nxt       = 1'b0;
                    w_state_nxt     = ST_GET_A;
                end
                default: begin
                    // Unreachable encoding: fall back to a clean idle state.
                    w_sum_nxt       = 5'd0;
                    w_sum_valid_nxt = 1'b0;
                    w_err_nxt       = 1'b0;
                    w_state_nxt     = ST_GET_A;
                end
            endcase
        end else begin
            w_state_nxt = r_state;
        end
    end

    // Entry FSM state and result registers.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            r_state     <= ST_GET_A;
            r_a         <= 4'd0;
            r_sum       <= 5'd0;
            r_sum_valid <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_a         <= w_a_nxt;
            r_sum       <= w_sum_nxt;
            r_sum_valid <= w_sum_valid_nxt;
            r_err       <= w_err_nxt;
        end
    end

    assign sum       = r_sum;
    assign sum_valid = r_sum_valid;
    assign state     = r_state;
    assign err       = r_err;

endmodule
